// File: rtl/safe_pkg.sv
// Shared types and constants for the safe-mode control stage.
//   ctrl_state_e : sequencer states (IDLE, ARM, SYNC)
//   REG_*        : register word indices on the register port
//   CTRL_* / SYNC_* : bit positions inside the CTRL and SYNC registers
package safe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SYNC = 2'd2
    } ctrl_state_e;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_MASTER = 2'd1;
    localparam logic [1:0] REG_SYNC   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_SAFE  = 0;
    localparam int CTRL_TMR   = 1;

    localparam int SYNC_START = 0;   // write side
    localparam int SYNC_ARM   = 0;   // read side
    localparam int SYNC_SYNC  = 1;   // read side
    localparam int SYNC_TO    = 2;   // read: flag, write 1: clear

endpackage

// File: rtl/safe_mode_ctrl_if.sv
// Register port of the safe-mode control stage.
//   req/we/addr/wdata : request, driven by the master
//   gnt               : same-cycle accept
//   rvalid/rdata/err  : response, one cycle after gnt
interface safe_mode_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/safe_mode_regif.sv
// Register decode and response pipeline.
// Checks every write against the current sequencer state and control bits,
// emits qualified write strobes to the core, and registers the response
// (rvalid/rdata/err) one cycle after the accept.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   bus                    : register port (slave side)
//   state_i, safe_i, tmr_i : current core state used by the write rules
//   rd_*_i                 : read views of the four registers
//   safe_we_o/tmr_we_o/master_we_o : apply CTRL bit0 / CTRL bit1 / MASTER
//   start_o, to_clr_o      : accepted sync start, timeout flag clear
module safe_mode_regif
    import safe_pkg::*;
#(
    parameter int NHARTS = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    safe_mode_ctrl_if.slave bus,
    input  ctrl_state_e  state_i,
    input  logic         safe_i,
    input  logic         tmr_i,
    input  logic [31:0]  rd_ctrl_i,
    input  logic [31:0]  rd_master_i,
    input  logic [31:0]  rd_sync_i,
    input  logic [31:0]  rd_status_i,
    output logic         safe_we_o,
    output logic         tmr_we_o,
    output logic         master_we_o,
    output logic         start_o,
    output logic         to_clr_o
);

    logic        wr;
    logic        locked;
    logic        onehot;
    logic        bad;
    logic        rvalid_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    assign bus.gnt    = bus.req;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;

    assign wr     = bus.req && bus.we;
    // tmr and master may only change while idle with safe mode off
    assign locked = (state_i != IDLE) || safe_i;
    // exactly one bit set, and it lies inside the master field
    assign onehot = (bus.wdata != 32'd0) && ((bus.wdata & (bus.wdata - 32'd1)) == 32'd0)
                    && ((bus.wdata >> NHARTS) == 32'd0);

    always_comb begin
        safe_we_o   = 1'b0;
        tmr_we_o    = 1'b0;
        master_we_o = 1'b0;
        start_o     = 1'b0;
        to_clr_o    = 1'b0;
        bad         = 1'b0;
        case (bus.addr)
            REG_CTRL: begin
                // bit0 always lands; a locked bit1 only errors if it would change
                bad       = locked && (bus.wdata[CTRL_TMR] != tmr_i);
                safe_we_o = wr;
                tmr_we_o  = wr && !bad;
            end
            REG_MASTER: begin
                bad         = locked || !onehot;
                master_we_o = wr && !bad;
            end
            REG_SYNC: begin
                bad      = bus.wdata[SYNC_START] && !(state_i == IDLE && safe_i && tmr_i);
                start_o  = wr && bus.wdata[SYNC_START] && !bad;
                to_clr_o = wr && bus.wdata[SYNC_TO] && !bad;
            end
            default: bad = 1'b1;   // STATUS is read-only
        endcase
    end

    always_comb begin
        rdata_d = 32'd0;
        if (bus.req && !bus.we) begin
            case (bus.addr)
                REG_CTRL:   rdata_d = rd_ctrl_i;
                REG_MASTER: rdata_d = rd_master_i;
                REG_SYNC:   rdata_d = rd_sync_i;
                default:    rdata_d = rd_status_i;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rvalid_q <= bus.req;
            err_q    <= wr && bad;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: rtl/safe_mode_ctrl.sv
// Control stage in front of the safe-mode lockstep FSM. Holds the mode,
// configuration and master-hart registers, sequences the initial-sync
// request (IDLE -> ARM -> SYNC -> IDLE) using Single_Bus_i, and aborts a
// sync that never starts with a watchdog and a sticky timeout flag.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   bus                    : register port (CTRL, MASTER, SYNC, STATUS)
//   Single_Bus_i           : single-bus indication from the lockstep FSM
//   Safe_mode_o, Safe_configuration_o, Master_Core_o : FSM configuration
//   Initial_Sync_Master_o  : one-hot sync request, live only in ARM
//   sync_busy_o            : ARM or SYNC
//   timeout_irq_o          : sticky timeout flag
module safe_mode_ctrl
    import safe_pkg::*;
#(
    parameter int NHARTS         = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    safe_mode_ctrl_if.slave   bus,
    input  logic              Single_Bus_i,
    output logic              Safe_mode_o,
    output logic              Safe_configuration_o,
    output logic [NHARTS-1:0] Master_Core_o,
    output logic [NHARTS-1:0] Initial_Sync_Master_o,
    output logic              sync_busy_o,
    output logic              timeout_irq_o
);

    ctrl_state_e       state_q;
    logic              safe_q, safe_d;
    logic              tmr_q;
    logic [NHARTS-1:0] master_q;
    logic [NHARTS-1:0] ism_q;
    logic              to_q;
    logic [CNT_W-1:0]  wd_q;
    logic [15:0]       nsync_q;

    logic safe_we, tmr_we, master_we, start, to_clr;

    safe_mode_regif #(.NHARTS(NHARTS)) u_regif (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .state_i     (state_q),
        .safe_i      (safe_q),
        .tmr_i       (tmr_q),
        .rd_ctrl_i   (32'({tmr_q, safe_q})),
        .rd_master_i (32'(master_q)),
        .rd_sync_i   (32'({to_q, state_q == SYNC, state_q == ARM})),
        .rd_status_i ({nsync_q, 16'(wd_q)}),
        .safe_we_o   (safe_we),
        .tmr_we_o    (tmr_we),
        .master_we_o (master_we),
        .start_o     (start),
        .to_clr_o    (to_clr)
    );

    // ARM reacts to a safe-mode clear in the same edge the register drops
    assign safe_d = safe_we ? bus.wdata[CTRL_SAFE] : safe_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            safe_q   <= 1'b0;
            tmr_q    <= 1'b1;
            master_q <= NHARTS'(1);
            ism_q    <= '0;
            to_q     <= 1'b0;
            wd_q     <= '0;
            nsync_q  <= 16'd0;
        end else begin
            safe_q <= safe_d;
            if (tmr_we)    tmr_q    <= bus.wdata[CTRL_TMR];
            if (master_we) master_q <= bus.wdata[NHARTS-1:0];
            if (to_clr)    to_q     <= 1'b0;   // a same-cycle timeout below wins

            case (state_q)
                IDLE: begin
                    wd_q <= '0;
                    if (start) begin
                        state_q <= ARM;
                        ism_q   <= master_q;
                    end
                end
                ARM: begin
                    if (!safe_d) begin
                        state_q <= IDLE;
                        ism_q   <= '0;
                    end else if (Single_Bus_i) begin
                        state_q <= SYNC;
                        ism_q   <= '0;
                    end else if (wd_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= IDLE;
                        ism_q   <= '0;
                        to_q    <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                SYNC: begin
                    if (!Single_Bus_i) begin
                        state_q <= IDLE;
                        if (nsync_q != 16'hFFFF) nsync_q <= nsync_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ism_q   <= '0;
                end
            endcase
        end
    end

    assign Safe_mode_o           = safe_q;
    assign Safe_configuration_o  = tmr_q;
    assign Master_Core_o         = master_q;
    assign Initial_Sync_Master_o = ism_q;
    assign sync_busy_o           = (state_q != IDLE);
    assign timeout_irq_o         = to_q;

endmodule

// File: tb/tb_safe_mode_ctrl.sv
// Directed bench for safe_mode_ctrl (NHARTS=3, TIMEOUT_CYCLES=8).
module tb_safe_mode_ctrl;

    localparam logic [1:0] A_CTRL = 2'd0, A_MAST = 2'd1, A_SYNC = 2'd2, A_STAT = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sb;
    logic       safe_m, cfg, busy, irq;
    logic [2:0] mast, ism;
    int         n_run = 0;
    int         n_fail = 0;
    int         hi;
    logic [31:0] r;
    logic        e;

    always #5 clk = ~clk;

    safe_mode_ctrl_if bus ();

    safe_mode_ctrl #(.NHARTS(3), .TIMEOUT_CYCLES(8)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .bus                   (bus),
        .Single_Bus_i          (sb),
        .Safe_mode_o           (safe_m),
        .Safe_configuration_o  (cfg),
        .Master_Core_o         (mast),
        .Initial_Sync_Master_o (ism),
        .sync_busy_o           (busy),
        .timeout_irq_o         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one access: drive at negedge, accept at posedge, sample response at next negedge
    task automatic acc(input logic w, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        #1 chk("gnt", 32'(bus.gnt), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rvalid", 32'(bus.rvalid), 32'd1);
        rd = bus.rdata;
        er = bus.err;
        bus.req = 1'b0; bus.we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic ee, input string tag);
        logic [31:0] x;
        logic        ev;
        acc(1'b1, a, d, x, ev);
        chk(tag, 32'(ev), 32'(ee));
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] x;
        logic        ev;
        acc(1'b0, a, 32'd0, x, ev);
        chk(tag, x, exp);
        chk({tag, "_err"}, 32'(ev), 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_safe"}, 32'(safe_m), 32'd0);
        chk({tag, "_cfg"}, 32'(cfg), 32'd1);
        chk({tag, "_mast"}, 32'(mast), 32'd1);
        chk({tag, "_ism"}, 32'(ism), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_irq"}, 32'(irq), 32'd0);
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_rdata"}, bus.rdata, 32'd0);
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
        rst_n = 1'b0; sb = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_reset_outs("rst");

        rd(A_CTRL, 32'h2, "rd_ctrl");
        rd(A_MAST, 32'h1, "rd_master");
        rd(A_SYNC, 32'h0, "rd_sync");
        rd(A_STAT, 32'h0, "rd_status");

        // normal sync: ARM for 5 cycles, SYNC for 10
        wr(A_MAST, 32'h4, 1'b0, "w_master");
        wr(A_CTRL, 32'h3, 1'b0, "w_ctrl");
        wr(A_SYNC, 32'h1, 1'b0, "w_start");
        hi = 0;
        if (ism == 3'h4) hi++;
        repeat (4) begin
            @(negedge clk);
            if (ism == 3'h4) hi++;
        end
        sb = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ism != 3'h0) hi++;
        end
        chk("ism_cycles", 32'(hi), 32'd5);
        chk("busy_sync", 32'(busy), 32'd1);
        repeat (7) @(negedge clk);
        sb = 1'b0;
        @(negedge clk);
        chk("busy_done", 32'(busy), 32'd0);
        acc(1'b0, A_STAT, 32'd0, r, e);
        chk("nsync", r >> 16, 32'd1);

        // watchdog timeout with Single_Bus held low
        wr(A_SYNC, 32'h1, 1'b0, "w_start2");
        hi = 0;
        repeat (12) begin
            if (ism == 3'h4) hi++;
            @(negedge clk);
        end
        chk("to_cycles", 32'(hi), 32'd8);
        chk("to_irq", 32'(irq), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        rd(A_SYNC, 32'h4, "rd_sync_to");
        wr(A_SYNC, 32'h4, 1'b0, "w1c");
        chk("irq_clr", 32'(irq), 32'd0);

        // rejected writes
        wr(A_MAST, 32'h1, 1'b1, "mast_locked");
        rd(A_MAST, 32'h4, "mast_keep1");
        wr(A_CTRL, 32'h0, 1'b1, "ctrl_mixed");
        rd(A_CTRL, 32'h2, "ctrl_mixed_rd");
        wr(A_MAST, 32'h3, 1'b1, "mast_onehot");
        rd(A_MAST, 32'h4, "mast_keep2");
        wr(A_MAST, 32'h2, 1'b0, "mast_ok");
        wr(A_CTRL, 32'h0, 1'b0, "ctrl_0");
        wr(A_CTRL, 32'h1, 1'b0, "ctrl_dmr");
        wr(A_SYNC, 32'h1, 1'b1, "start_dmr");
        chk("dmr_busy", 32'(busy), 32'd0);
        rd(A_SYNC, 32'h0, "dmr_sync");
        wr(A_STAT, 32'h0, 1'b1, "status_ro");
        sb = 1'b1;
        @(negedge clk);
        chk("sb_idle", 32'(busy), 32'd0);
        sb = 1'b0;

        // abort from ARM by clearing safe mode
        wr(A_CTRL, 32'h0, 1'b0, "ab_c0");
        wr(A_CTRL, 32'h2, 1'b0, "ab_c2");
        wr(A_CTRL, 32'h3, 1'b0, "ab_c3");
        wr(A_SYNC, 32'h1, 1'b0, "ab_start");
        chk("ab_ism_on", 32'(ism), 32'h2);
        @(negedge clk);
        wr(A_CTRL, 32'h2, 1'b0, "ab_clear");
        chk("ab_safe", 32'(safe_m), 32'd0);
        chk("ab_ism", 32'(ism), 32'd0);
        repeat (12) @(negedge clk);
        chk("ab_irq", 32'(irq), 32'd0);
        rd(A_SYNC, 32'h0, "ab_sync");

        // reset while in SYNC
        wr(A_CTRL, 32'h3, 1'b0, "rs_ctrl");
        wr(A_SYNC, 32'h1, 1'b0, "rs_start");
        sb = 1'b1;
        repeat (3) @(negedge clk);
        rd(A_SYNC, 32'h2, "rs_in_sync");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_outs("rs");
        @(negedge clk);
        chk("rs_sb_idle", 32'(busy), 32'd0);
        sb = 1'b0;
        rd(A_STAT, 32'h0, "rs_status");
        rd(A_MAST, 32'h1, "rs_master");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
